// File: rtl/io_arb_pkg.sv
// Shared constants for the I/O memory arbiter: FSM encoding, owner encoding,
// default burst-length width and the burst word-address helper.
package io_arb_pkg;

   localparam int LEN_W_DEF = 8;

   typedef logic [1:0] state_t;
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_BURST = 2'd1;
   localparam logic [1:0] S_INTR  = 2'd2;

   localparam logic OWN_CPU = 1'b0;
   localparam logic OWN_DEV = 1'b1;

   // Byte address of word idx in a burst; wraps modulo 2^32.
   function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [29:0] idx);
      return base + {idx, 2'b00};
   endfunction

endpackage

// File: rtl/io_addr_gen.sv
// Burst base register plus word counter; drives the peripheral memory address
// and the current word index.
module io_addr_gen
   import io_arb_pkg::*;
#(
   parameter int LEN_W = LEN_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic [31:0]      base_i,
   input  logic             inc_i,
   output logic [31:0]      io_addr_o,
   output logic [LEN_W-1:0] dev_idx_o
);

   logic [31:0]      base_q, base_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;

   always_comb begin
      base_d = base_q;
      cnt_d  = cnt_q;
      if (load_i) begin
         base_d = base_i;
         cnt_d  = '0;
      end else if (inc_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         base_q <= '0;
         cnt_q  <= '0;
      end else begin
         base_q <= base_d;
         cnt_q  <= cnt_d;
      end
   end

   assign io_addr_o = word_addr(base_q, 30'(cnt_q));
   assign dev_idx_o = cnt_q;

endmodule

// File: rtl/io_arbiter.sv
// Shares the single-ported I/O memory between the CPU and a burst peripheral,
// alternating cycles under contention and interrupting after write bursts.
module io_arbiter
   import io_arb_pkg::*;
#(
   parameter int LEN_W = LEN_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cpu_cs,
   input  logic             cpu_rd,
   input  logic             cpu_wr,
   input  logic [31:0]      cpu_addr,
   input  logic [31:0]      cpu_din,
   output logic [31:0]      cpu_dout,
   output logic             cpu_stall,
   input  logic             dev_req,
   input  logic             dev_wr,
   input  logic [31:0]      dev_addr,
   input  logic [LEN_W-1:0] dev_len,
   input  logic [31:0]      dev_din,
   output logic             dev_gnt,
   output logic             dev_beat,
   output logic [LEN_W-1:0] dev_idx,
   output logic [31:0]      dev_dout,
   output logic             dev_done,
   output logic             intr,
   input  logic             inta,
   output logic             io_cs,
   output logic             io_rd,
   output logic             io_wr,
   output logic [31:0]      io_addr,
   output logic [31:0]      io_din,
   input  logic [31:0]      io_dout
);

   state_t           state_q, state_d;
   logic             last_owner_q, last_owner_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic             dir_q, dir_d;
   logic             done_q, done_d;

   logic             cpu_active, in_burst, cpu_own, dev_own, last_beat, load;
   logic [31:0]      gen_addr;

   io_addr_gen #(.LEN_W(LEN_W)) u_addr_gen (
      .clk       (clk),
      .reset     (reset),
      .load_i    (load),
      .base_i    (dev_addr),
      .inc_i     (dev_own),
      .io_addr_o (gen_addr),
      .dev_idx_o (dev_idx)
   );

   assign cpu_active = cpu_cs & (cpu_rd | cpu_wr);
   assign in_burst   = (state_q == S_BURST);
   assign cpu_own    = in_burst & cpu_active & (last_owner_q == OWN_DEV);
   // A beat is suppressed while reset is held so an aborted burst writes nothing further.
   assign dev_own    = in_burst & ~cpu_own & ~reset;
   assign last_beat  = dev_own & (dev_idx == len_q - 1'b1);

   assign dev_gnt  = in_burst;
   assign dev_beat = dev_own;
   assign dev_done = done_q;
   assign intr     = (state_q == S_INTR);

   always_comb begin
      if (dev_own) begin
         io_cs     = 1'b1;
         io_rd     = ~dir_q;
         io_wr     = dir_q;
         io_addr   = gen_addr;
         io_din    = dev_din;
         dev_dout  = io_dout;
         cpu_dout  = '0;
         cpu_stall = cpu_active;
      end else begin
         io_cs     = cpu_cs;
         io_rd     = cpu_rd;
         io_wr     = cpu_wr;
         io_addr   = cpu_addr;
         io_din    = cpu_din;
         dev_dout  = '0;
         cpu_dout  = io_dout;
         cpu_stall = 1'b0;
      end
   end

   always_comb begin
      state_d      = state_q;
      last_owner_d = last_owner_q;
      len_d        = len_q;
      dir_d        = dir_q;
      done_d       = 1'b0;
      load         = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (dev_req) begin
               if (dev_len != '0) begin
                  load         = 1'b1;
                  len_d        = dev_len;
                  dir_d        = dev_wr;
                  last_owner_d = OWN_CPU;
                  state_d      = S_BURST;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         S_BURST: begin
            if (cpu_own) begin
               last_owner_d = OWN_CPU;
            end else if (dev_own) begin
               last_owner_d = OWN_DEV;
               if (last_beat) begin
                  done_d  = 1'b1;
                  state_d = dir_q ? S_INTR : S_IDLE;
               end
            end
         end
         S_INTR: begin
            if (inta) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         last_owner_q <= OWN_CPU;
         len_q        <= '0;
         dir_q        <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_owner_q <= last_owner_d;
         len_q        <= len_d;
         dir_q        <= dir_d;
         done_q       <= done_d;
      end
   end

endmodule
